tone_oscillator: RTL and testbench
==================================

// Module: tone_oscillator
// PURPOSE
//  Phase-accumulator tone generator that produces one 11-bit unsigned voice sample
//  (channel1/channel2 of the audio controller) at a fixed sample rate.
//  - Waveforms: square, saw, triangle, silence.
//  - Pitch and waveform are loaded through a valid/ready config port.
//  - A new config takes effect only on a sample boundary, so it cannot glitch a sample.
//  - One instance per voice; outputs go straight to the audio controller channel inputs.
// PARAMETERS
//  CLK_HZ     400_000  system clock frequency
//  SAMPLE_HZ  8_000    output sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer, >=2)
//  PHASE_W    24       phase accumulator / increment width (>=12)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  ena          in   1        1 = run; 0 = freeze divider, phase and output
//  i_valid      in   1        config request
//  i_ready      out  1        config slot empty; transfer when i_valid & i_ready
//  i_phase_inc  in   PHASE_W  phase increment per sample; f = inc*SAMPLE_HZ/2^PHASE_W
//  i_wave       in   2        00 square, 01 saw, 10 triangle, 11 silence
//  i_sync       in   1        1 = zero the phase when this config is applied
//  o_strobe     out  1        one-cycle pulse; channel holds a new sample
//  channel      out  11       unsigned sample, midscale 1024
// BEHAVIOUR
//  Reset (rst=0, async): div_cnt=0, phase=0, inc=0, wave=11, pending=0,
//   i_ready=1, o_strobe=0, channel=1024.
//  Divider
//   - When ena=1, div_cnt counts 0..DIV-1 and wraps.
//   - tick = ena & (div_cnt==DIV-1).
//   - When ena=0, div_cnt holds, and phase and channel hold.
//  Config port (1-entry holding register)
//   - i_ready = ~pending.
//   - On i_valid & i_ready: latch inc/wave/sync into a holding register; pending<=1.
//   - Accepting a config is independent of ena.
//   - On a tick edge with pending=1: active inc/wave take the held values; pending<=0.
//   - i_ready returns to 1 on the cycle after that tick.
//   - Config accepted on the tick edge itself (pending was 0): applies at the NEXT tick.
//  Phase update (tick edge)
//   - phase <= (sync_applied ? 0 : phase) + inc_new, modulo 2^PHASE_W.
//   - inc_new is the increment being applied on this edge if one is; otherwise the active one.
//   - Wrap is silent, with no saturation.
//  Output stage (registered, the edge after the tick edge)
//   - Computed from the updated phase P and the active wave.
//   - square:   P[MSB] ? 2047 : 0
//   - saw:      P[PHASE_W-1 -: 11]
//   - triangle: t = P[PHASE_W-1 -: 12]; t[11] ? ~t[10:0] : t[10:0]
//   - silence:  1024
//   - o_strobe is 1 for exactly that cycle; otherwise 0.
//   - Strobe period = DIV cycles while ena=1.
//   - First strobe after reset release appears on the DIV+1-th rising edge.
//  Simultaneous events
//   - ena falling on a tick cycle: tick=0 (ena gates it), so no update occurs.
//   - ena low: strobe never asserts; no pipeline output is lost or duplicated.
//   - Reset mid-operation: all state returns to reset values immediately;
//     any pending config is discarded.
// TESTING (DIV=50, PHASE_W=24)
//  1 Reset/idle: release rst, ena=1, no config
//    -> o_strobe every 50 cycles, first on edge 51; channel stays 1024.
//  2 Saw: config inc=2^20, wave=01, sync=1
//    -> successive strobes give 128,256,...,1920, then 0; the sequence repeats every 16 samples.
//  3 Square then triangle: inc=2^22, wave=00, sync=1
//    -> 0,2047,2047,0 repeating; reconfigure wave=10, sync=1 -> 1024,2047,1023,0.
//  4 Handshake: two configs back-to-back
//    -> first taken; i_ready=0 until the cycle after the next tick;
//       second held by i_valid and taken then, applied one tick later;
//       no sample mixes old and new settings.
//  5 ena gap / wrap: inc=2^24-1, saw, ena=0 for 120 cycles mid-period
//    -> no strobes and channel frozen during the gap; on resume the
//       phase sequence continues, decreasing by 1 LSB each sample, with no skipped sample.
//  6 Async reset mid-run: pulse rst low between clock edges with pending=1
//    -> outputs reach reset values without a clock edge; pending cleared; i_ready=1.

Source files
------------

// File: rtl/tone_oscillator.sv
// -----------------------------------------------------------------------------
// tone_oscillator
//
// Phase-accumulator voice generator. It produces one 11-bit unsigned sample
// (midscale 1024) per sample period, in square, saw, triangle or silence.
// Pitch and waveform arrive on a valid/ready config port that has a 1-entry
// holding register. A held config takes effect only on a sample tick, so no
// sample ever mixes old and new settings.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ena          1 = run; 0 = freeze divider, phase and output
//   i_valid      config request
//   i_ready      holding register empty; a transfer happens on i_valid & i_ready
//   i_phase_inc  phase increment per sample (f = inc*SAMPLE_HZ/2^PHASE_W)
//   i_wave       00 square, 01 saw, 10 triangle, 11 silence
//   i_sync       zero the phase when this config is applied
//   o_strobe     one-cycle pulse: channel holds a new sample
//   channel      unsigned sample, midscale 1024
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tone_oscillator #(
  parameter int CLK_HZ    = 400_000,
  parameter int SAMPLE_HZ = 8_000,
  parameter int PHASE_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [PHASE_W-1:0] i_phase_inc,
  input  logic [1:0]         i_wave,
  input  logic               i_sync,
  output logic               o_strobe,
  output logic [10:0]        channel
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    WAVE_SQUARE  = 2'b00,
    WAVE_SAW     = 2'b01,
    WAVE_TRI     = 2'b10,
    WAVE_SILENCE = 2'b11
  } wave_e;

  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  wave_e              wave_q, wave_d;
  logic               pending_q, pending_d;
  logic [PHASE_W-1:0] hold_inc_q;
  wave_e              hold_wave_q;
  logic               hold_sync_q;
  logic               out_due_q, out_due_d;   // phase updated, sample not yet emitted
  logic               strobe_q, strobe_d;
  logic [10:0]        channel_q, channel_d;

  logic               tick, accept, apply;
  logic [PHASE_W-1:0] inc_new, phase_base;
  logic [11:0]        tri_t;
  logic [10:0]        sample;

  assign tick    = ena && (div_cnt_q == DIV_LAST);
  assign accept  = i_valid && !pending_q;
  // A config that was already held is applied on a tick. A config accepted on
  // that same edge (pending was 0) therefore waits for the following tick.
  assign apply   = tick && pending_q;
  assign inc_new = apply ? hold_inc_q : inc_q;
  assign phase_base = (apply && hold_sync_q) ? '0 : phase_q;

  // Sample shaping from the already-updated phase and the active wave.
  assign tri_t = phase_q[PHASE_W-1 -: 12];
  always_comb begin
    sample = 11'd1024;
    case (wave_q)
      WAVE_SQUARE:  sample = {11{phase_q[PHASE_W-1]}};
      WAVE_SAW:     sample = phase_q[PHASE_W-1 -: 11];
      WAVE_TRI:     sample = tri_t[11] ? ~tri_t[10:0] : tri_t[10:0];
      WAVE_SILENCE: sample = 11'd1024;
      default:      sample = 11'd1024;
    endcase
  end

  // NOTE: every signal gets a default at the top of the process, so a path
  // that does not assign it cannot infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    wave_d    = wave_q;
    pending_d = pending_q;
    out_due_d = out_due_q;
    strobe_d  = 1'b0;
    channel_d = channel_q;

    if (ena) begin
      div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
      // The output stage waits while frozen, so a sample whose phase was
      // computed just before ena fell is emitted after resume, not dropped.
      if (out_due_q) begin
        strobe_d  = 1'b1;
        channel_d = sample;
        out_due_d = 1'b0;
      end
    end

    if (tick) begin
      phase_d   = phase_base + inc_new;   // wraps modulo 2^PHASE_W
      out_due_d = 1'b1;
      if (apply) begin
        inc_d     = hold_inc_q;
        wave_d    = hold_wave_q;
        pending_d = 1'b0;
      end
    end

    if (accept) pending_d = 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      phase_q     <= '0;
      inc_q       <= '0;
      wave_q      <= WAVE_SILENCE;
      pending_q   <= 1'b0;
      hold_inc_q  <= '0;
      hold_wave_q <= WAVE_SILENCE;
      hold_sync_q <= 1'b0;
      out_due_q   <= 1'b0;
      strobe_q    <= 1'b0;
      channel_q   <= 11'd1024;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      wave_q    <= wave_d;
      pending_q <= pending_d;
      out_due_q <= out_due_d;
      strobe_q  <= strobe_d;
      channel_q <= channel_d;
      if (accept) begin
        hold_inc_q  <= i_phase_inc;
        hold_wave_q <= wave_e'(i_wave);
        hold_sync_q <= i_sync;
      end
    end
  end

  assign i_ready  = !pending_q;
  assign o_strobe = strobe_q;
  assign channel  = channel_q;

endmodule

// File: tb/tb_tone_oscillator.sv
// -----------------------------------------------------------------------------
// tb_tone_oscillator
//
// Directed bench for tone_oscillator (DIV=50, PHASE_W=24). A behavioural model
// tracks the expected i_ready / o_strobe / channel from the enabled-cycle
// count and an integer phase, and a compare process checks the DUT against it
// on every falling edge. Directed sequences also pin literal sample values,
// strobe spacing and the reset behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_oscillator;

  localparam int    DIV = 50;
  localparam longint MOD = 64'd16777216;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [23:0] i_phase_inc = '0;
  logic [1:0]  i_wave = 2'b11;
  logic        i_sync = 1'b0;
  logic        o_strobe;
  logic [10:0] channel;

  int n_checks = 0;
  int n_errors = 0;

  tone_oscillator #(.CLK_HZ(400_000), .SAMPLE_HZ(8_000), .PHASE_W(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_phase_inc (i_phase_inc),
    .i_wave      (i_wave),
    .i_sync      (i_sync),
    .o_strobe    (o_strobe),
    .channel     (channel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_cnt;      // enabled clock edges since reset
  longint m_phase;
  longint m_inc;
  int     m_wave;
  bit     m_pend;
  longint h_inc;
  int     h_wave;
  bit     h_sync;
  bit     m_due;
  bit     m_strobe;
  int     m_chan;

  function automatic int shape(input longint p, input int w);
    int t;
    case (w)
      0: return (p >= 64'd8388608) ? 2047 : 0;
      1: return int'(p / 8192);
      2: begin
        t = int'(p / 4096);
        return (t >= 2048) ? 4095 - t : t;
      end
      default: return 1024;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    bit tick, acc;
    if (!rst) begin
      m_cnt = 0; m_phase = 0; m_inc = 0; m_wave = 3; m_pend = 0;
      h_inc = 0; h_wave = 3; h_sync = 0; m_due = 0; m_strobe = 0; m_chan = 1024;
    end else begin
      tick = ena && (m_cnt % DIV == DIV - 1);
      acc  = i_valid && !m_pend;
      m_strobe = 0;
      if (ena && m_due) begin
        m_strobe = 1;
        m_chan   = shape(m_phase, m_wave);
        m_due    = 0;
      end
      if (tick) begin
        if (m_pend) begin
          if (h_sync) m_phase = 0;
          m_inc  = h_inc;
          m_wave = h_wave;
          m_pend = 0;
        end
        m_phase = (m_phase + m_inc) % MOD;
        m_due   = 1;
      end
      if (acc) begin
        h_inc = longint'(i_phase_inc); h_wave = int'(i_wave); h_sync = i_sync;
        m_pend = 1;
      end
      if (ena) m_cnt++;
    end
  end

  // Compare process: outputs settle long before the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("model_strobe",  int'(o_strobe), int'(m_strobe));
      check("model_channel", int'(channel),  m_chan);
      check("model_ready",   int'(i_ready),  int'(!m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Starts at a falling edge; returns at the falling edge where o_strobe is 1.
  task automatic wait_strobe(output int n, output int ch);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_strobe && n < 300);
    if (!o_strobe) check("strobe_timeout", 0, 1);
    ch = int'(channel);
  endtask

  // Starts at a falling edge; presents a config and returns at the falling
  // edge after the accepting clock edge, with i_valid still high.
  task automatic cfg_send(input logic [23:0] inc, input logic [1:0] w, input logic s);
    bit rdy;
    int guard;
    i_valid = 1'b1; i_phase_inc = inc; i_wave = w; i_sync = s;
    guard = 0;
    rdy = i_ready;
    while (!rdy && guard < 300) begin
      @(negedge clk);
      guard++;
      rdy = i_ready;
    end
    if (!rdy) check("cfg_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_idle();
    i_valid = 1'b0;
  endtask

  int n, ch;
  int exp_sq[4]  = '{0, 2047, 2047, 0};
  int exp_tri[4] = '{1024, 2047, 1023, 0};

  initial begin
    // ---- 1: reset / idle ----
    repeat (2) @(negedge clk);
    check("reset_ready",   int'(i_ready),  1);
    check("reset_strobe",  int'(o_strobe), 0);
    check("reset_channel", int'(channel),  1024);
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("no_strobe_edge50", int'(o_strobe), 0);
    @(posedge clk);
    #1 check("first_strobe_edge51", int'(o_strobe), 1);
    check("idle_channel", int'(channel), 1024);
    @(negedge clk);
    wait_strobe(n, ch);
    check("strobe_period", n, 50);
    check("idle_channel2", ch, 1024);

    // ---- 2: saw, inc=2^20 ----
    cfg_send(24'h10_0000, 2'b01, 1'b1);
    cfg_idle();
    for (int k = 1; k <= 17; k++) begin
      wait_strobe(n, ch);
      check("saw_sample", ch, (k * 128) % 2048);
    end

    // ---- 3: square then triangle, inc=2^22 ----
    cfg_send(24'h40_0000, 2'b00, 1'b1);
    cfg_idle();
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n, ch);
      check("square_sample", ch, exp_sq[k]);
    end
    cfg_send(24'h40_0000, 2'b10, 1'b1);
    cfg_idle();
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n, ch);
      check("tri_sample", ch, exp_tri[k]);
    end

    // ---- 4: back-to-back configs ----
    cfg_send(24'h10_0000, 2'b01, 1'b1);
    check("busy_after_accept", int'(i_ready), 0);
    cfg_send(24'h40_0000, 2'b00, 1'b1);
    // The second config is taken on the edge after the tick, which is
    // also the edge that emits the first sample of the first config.
    check("b2b_first_strobe", int'(o_strobe), 1);
    check("b2b_first_sample", int'(channel), 128);
    cfg_idle();
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n, ch);
      check("b2b_square_sample", ch, exp_sq[k]);
    end

    // ---- 5: ena gap with wrapping increment ----
    cfg_send(24'hFF_FFFF, 2'b01, 1'b1);
    cfg_idle();
    wait_strobe(n, ch);
    check("wrap_first_sample", ch, 2047);
    repeat (20) @(negedge clk);
    ena = 1'b0;
    repeat (120) @(negedge clk);
    ena = 1'b1;
    wait_strobe(n, ch);
    check("gap_resume_delay", n, 30);
    check("gap_sample", ch, 2047);
    wait_strobe(n, ch);
    check("gap_period_after", n, 50);

    // ---- 6: async reset with a pending config ----
    cfg_send(24'h20_0000, 2'b00, 1'b0);
    cfg_idle();
    check("pending_before_reset", int'(i_ready), 0);
    #2 rst = 1'b0;
    #1;
    check("async_ready",   int'(i_ready),  1);
    check("async_strobe",  int'(o_strobe), 0);
    check("async_channel", int'(channel),  1024);
    #1 rst = 1'b1;
    wait_strobe(n, ch);
    check("post_reset_first_strobe", n, 51);
    check("post_reset_discarded_cfg", ch, 1024);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
